// File: rtl/pipelined_mul_unit_if.sv
// Handshake bundle for the pipelined multiplier: issue side plus result side.
// master: the core that issues operations and consumes results.
// slave : the multiplier.
//   in_valid/in_ready/in_op/in_a/in_b/in_tag   operation issue
//   out_valid/out_ready/out_data/out_tag       result return
interface pipelined_mul_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_mul_unit.sv
// Purpose: RV-style integer multiplier (MUL/MULH/MULHSU/MULHU) with STAGES-deep elastic pipeline.
// Latency: STAGES cycles from acceptance to out_valid when the consumer keeps out_ready high.
// Backpressure: a stalled last stage holds its result; upstream bubbles collapse, in_ready drops when full.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset (rst wins over flush)
//   flush      drops every in-flight operation at the next edge
//   bus        pipelined_mul_unit_if.slave: issue handshake and result handshake
//   busy       high while any stage holds an operation
//   perf_ops   (MUL_PERF_CNT_EN only) completed result handshakes, wraps at 2^32
//   perf_stall (MUL_PERF_CNT_EN only) cycles with a result held by out_ready low
// Optional feature macro: MUL_PERF_CNT_EN.
module pipelined_mul_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 5,   // legal range 1..8
  parameter int TAG_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pipelined_mul_unit_if.slave    bus,
  output logic                   busy
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_stall
`endif
);

  localparam int PW = 2 * XLEN;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  // Stage storage. Stage STAGES-1 is the output stage.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [PW-1:0]     prod_q [STAGES];
  logic [PW-1:0]     prod_d [STAGES];
  logic [1:0]        op_q   [STAGES];
  logic [1:0]        op_d   [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];

  // open[i]: stage i is empty or will hand its content on at this edge.
  logic [STAGES-1:0] open;
  logic [STAGES-1:0] ld;
  logic              accept;

  // Operands are sign- or zero-extended to the full product width; the
  // product modulo 2^(2*XLEN) is then exact for every signedness mix.
  logic              a_sgn;
  logic              b_sgn;
  logic [PW-1:0]     a_x;
  logic [PW-1:0]     b_x;
  logic [PW-1:0]     prod_x;

  assign a_sgn  = (bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU);
  assign b_sgn  = (bus.in_op == OP_MULH);
  assign a_x    = {{XLEN{a_sgn & bus.in_a[XLEN-1]}}, bus.in_a};
  assign b_x    = {{XLEN{b_sgn & bus.in_b[XLEN-1]}}, bus.in_b};
  assign prod_x = a_x * b_x;

  // A stage is open when some stage at or after it is empty, or the
  // consumer is taking the result; this lets bubbles collapse.
  always_comb begin
    logic all_v;
    all_v = 1'b1;
    open  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      all_v   = all_v & vld_q[i];
      open[i] = bus.out_ready | ~all_v;
    end
  end

  assign bus.in_ready = open[0] & ~flush & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    ld        = '0;
    vld_d     = '0;
    ld[0]     = accept;
    prod_d[0] = prod_x;
    op_d[0]   = bus.in_op;
    tag_d[0]  = bus.in_tag;
    for (int i = 1; i < STAGES; i++) begin
      ld[i]     = vld_q[i-1] & open[i-1];
      prod_d[i] = prod_q[i-1];
      op_d[i]   = op_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      vld_d[i] = ld[i] | (vld_q[i] & ~open[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    // Payload needs no reset: it is only observed behind its valid bit.
    for (int i = 0; i < STAGES; i++) begin
      if (ld[i]) begin
        prod_q[i] <= prod_d[i];
        op_q[i]   <= op_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  logic [XLEN-1:0] result;
  assign result = (op_q[STAGES-1] == OP_MUL) ? prod_q[STAGES-1][XLEN-1:0]
                                             : prod_q[STAGES-1][PW-1:XLEN];

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_data  = bus.out_valid ? result : '0;
  assign bus.out_tag   = bus.out_valid ? tag_q[STAGES-1] : '0;
  assign busy          = |vld_q;

`ifdef MUL_PERF_CNT_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;

  // Counters survive flush; a handshake in the flush cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
      if (bus.out_valid && !bus.out_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_pipelined_mul_unit.sv
// Directed bench for pipelined_mul_unit (XLEN=32, STAGES=5, TAG_W=6).
// A negedge monitor checks every result handshake against an in-order
// expected queue, plus held-output stability and zeroed idle outputs.
module tb_pipelined_mul_unit;
  localparam int XLEN   = 32;
  localparam int STAGES = 5;
  localparam int TAG_W  = 6;

  localparam logic [1:0] MUL    = 2'd0;
  localparam logic [1:0] MULH   = 2'd1;
  localparam logic [1:0] MULHSU = 2'd2;
  localparam logic [1:0] MULHU  = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
`ifdef MUL_PERF_CNT_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
`endif

  pipelined_mul_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus_if ();

  pipelined_mul_unit #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus_if),
    .busy       (busy)
`ifdef MUL_PERF_CNT_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  tag;
    int          cyc;   // expected arrival cycle, -1 when not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Output monitor.
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data;
  logic [5:0]  hold_tag;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!bus_if.out_valid) begin
      chk("idle_data", 64'(bus_if.out_data), 64'd0);
      chk("idle_tag", 64'(bus_if.out_tag), 64'd0);
    end
    if (hold_prev && bus_if.out_valid) begin
      chk("hold_data", 64'(bus_if.out_data), 64'(hold_data));
      chk("hold_tag", 64'(bus_if.out_tag), 64'(hold_tag));
    end
    if (bus_if.out_valid && bus_if.out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(bus_if.out_tag), 64'h3f_dead);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_tag", 64'(bus_if.out_tag), 64'(mon_e.tag));
        chk("out_data", 64'(bus_if.out_data), 64'(mon_e.data));
        if (mon_e.cyc >= 0) chk("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    hold_prev = bus_if.out_valid && !bus_if.out_ready && !rst && !flush;
    hold_data = bus_if.out_data;
    hold_tag  = bus_if.out_tag;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, retrying while in_ready is low; optionally queue its result.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic [31:0] want,
                       input bit lat, input bit track);
    bit   done = 1'b0;
    exp_t e;
    bus_if.in_valid = 1'b1;
    bus_if.in_op    = op;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    bus_if.in_tag   = tag;
    for (int w = 0; w < 80 && !done; w++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        done = 1'b1;
        if (track) begin
          e.data = want;
          e.tag  = tag;
          e.cyc  = lat ? cyc + STAGES : -1;
          exp_q.push_back(e);
        end
      end
      tick();
    end
    bus_if.in_valid = 1'b0;
    if (!done) chk("issue_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && exp_q.size() != 0; w++) tick();
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    flush            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_op     = 2'd0;
    bus_if.in_a      = '0;
    bus_if.in_b      = '0;
    bus_if.in_tag    = '0;
    bus_if.out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    tick();
    rst              = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus_if.in_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
`ifdef MUL_PERF_CNT_EN
    chk("perf_ops_reset", 64'(perf_ops), 64'd0);
    chk("perf_stall_reset", 64'(perf_stall), 64'd0);
`endif
    tick();

    // Four ops back-to-back, exact latency.
    issue(MUL,    32'h0001_0000, 32'h0001_0000, 6'd1, 32'h0000_0000, 1'b1, 1'b1);
    issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 32'hFFFF_FFFE, 1'b1, 1'b1);
    issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 32'h0000_0000, 1'b1, 1'b1);
    issue(MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 6'd4, 32'hFFFF_FFFF, 1'b1, 1'b1);
    @(negedge clk);
    chk("busy_inflight", 64'(busy), 64'd1);
    tick();
    drain();

    // Sign corner cases.
    issue(MULH,   32'h8000_0000, 32'h8000_0000, 6'd5,  32'h4000_0000, 1'b1, 1'b1);
    issue(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 6'd6,  32'h8000_0000, 1'b1, 1'b1);
    issue(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7,  32'h0000_0001, 1'b1, 1'b1);
    issue(MUL,    32'd7,         32'd6,         6'd8,  32'd42,        1'b1, 1'b1);
    issue(MULHU,  32'h8000_0000, 32'h0000_0002, 6'd9,  32'h0000_0001, 1'b1, 1'b1);
    issue(MULH,   32'hFFFF_FFFE, 32'h0000_0003, 6'd10, 32'hFFFF_FFFF, 1'b1, 1'b1);
    drain();
`ifdef MUL_PERF_CNT_EN
    chk("perf_ops_10", 64'(perf_ops), 64'd10);
    chk("perf_stall_0", 64'(perf_stall), 64'd0);
`endif

    // Eight ops with out_ready low for relative cycles 3..12.
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue(MUL, 32'(i + 1), 32'd3, 6'(16 + i), 32'(3 * (i + 1)), 1'b0, 1'b1);
      end
      begin
        for (int r = 0; r < 14; r++) begin
          bus_if.out_ready = !(r >= 3 && r <= 12);
          @(negedge clk);
          if (r == 4) chk("stall_in_ready_r4", 64'(bus_if.in_ready), 64'd1);
          if (r == 8) begin
            chk("stall_in_ready_full", 64'(bus_if.in_ready), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
          end
          tick();
        end
      end
    join
    bus_if.out_ready = 1'b1;
    drain();
`ifdef MUL_PERF_CNT_EN
    chk("perf_stall_8", 64'(perf_stall), 64'd8);
    chk("perf_ops_18", 64'(perf_ops), 64'd18);
`endif

    // Single op, then a stream against a toggling consumer.
    issue(MUL, 32'd5, 32'd5, 6'd32, 32'd25, 1'b1, 1'b1);
    drain();
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue(MUL, 32'(100 * (i + 1)), 32'd2, 6'(33 + i), 32'(200 * (i + 1)), 1'b0, 1'b1);
      end
      begin
        for (int r = 0; r < 40; r++) begin
          bus_if.out_ready = (r % 2) == 0;
          tick();
        end
        bus_if.out_ready = 1'b1;
      end
    join
    drain();

    // Flush with three ops in flight; the oldest is handed off in the flush cycle.
    issue(MUL, 32'd2, 32'd3, 6'd40, 32'd6, 1'b1, 1'b1);
    issue(MUL, 32'd4, 32'd3, 6'd41, 32'd12, 1'b1, 1'b1);
    issue(MUL, 32'd5, 32'd3, 6'd42, 32'd15, 1'b1, 1'b1);
    tick();
    tick();
    flush           = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_op    = MUL;
    bus_if.in_a     = 32'd9;
    bus_if.in_b     = 32'd9;
    bus_if.in_tag   = 6'd43;
    @(negedge clk);
    chk("flush_in_ready", 64'(bus_if.in_ready), 64'd0);
    chk("flush_out_valid", 64'(bus_if.out_valid), 64'd1);
    tick();
    flush           = 1'b0;
    bus_if.in_valid = 1'b0;
    chk("flush_dropped", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    @(negedge clk);
    chk("post_flush_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("post_flush_busy", 64'(busy), 64'd0);
    tick();
    for (int i = 0; i < 8; i++) tick();
    issue(MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 6'd44, 32'h0000_0001, 1'b1, 1'b1);
    drain();
`ifdef MUL_PERF_CNT_EN
    chk("perf_ops_flush", 64'(perf_ops), 64'd27);
`endif

    // Reset with a full pipe.
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(MUL, 32'(i + 1), 32'd1, 6'(50 + i), 32'(i + 1), 1'b0, 1'b0);
    @(negedge clk);
    chk("full_busy", 64'(busy), 64'd1);
    chk("full_in_ready", 64'(bus_if.in_ready), 64'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus_if.in_ready), 64'd0);
    tick();
    rst              = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
`ifdef MUL_PERF_CNT_EN
    chk("post_rst_perf_ops", 64'(perf_ops), 64'd0);
    chk("post_rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
    tick();
    for (int i = 0; i < 10; i++) tick();
    issue(MUL, 32'd9, 32'd9, 6'd55, 32'd81, 1'b1, 1'b1);
    drain();

    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
